// File: rtl/key_rect_painter.sv
// key_rect_painter: queued rectangle-fill engine streaming one pixel per cycle to a VGA plot port.
// Define KEY_RECT_BORDER_EN to draw each key with a colour-0 outline.
module key_rect_painter #(
  parameter int NUM_KEYS   = 12,
  parameter int KEY_W      = 20,
  parameter int KEY_H      = 40,
  parameter int X_ORIGIN   = 40,
  parameter int Y_ORIGIN   = 160,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int COLOUR_W   = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int KW        = $clog2(NUM_KEYS + 1)
) (
  input  logic                iClock,
  input  logic                iResetn,
  input  logic                iReqValid,
  input  logic [KW-1:0]       iReqKey,
  input  logic [COLOUR_W-1:0] iReqColour,
  output logic                oReqReady,
  output logic [X_W-1:0]      oX,
  output logic [Y_W-1:0]      oY,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oPlot,
  output logic                oBusy,
  output logic                oDone,
  output logic                oDrop
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(KEY_W + 1);
  localparam int RW = $clog2(KEY_H + 1);
  localparam int XI = X_W + 2;
  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
  state_t state, state_n;
  logic [KW+COLOUR_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [KW-1:0] key_q;
  logic [COLOUR_W-1:0] colour_q, pix_colour;
  logic [XI-1:0] base_x, x_full;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic push, pop, last_col, last_px, bad_key;
  assign oReqReady = count != (AW+1)'(FIFO_DEPTH);
  assign push = iReqValid && oReqReady;
  assign pop = state == IDLE && count != '0;
  assign oBusy = state != IDLE || count != '0;
  assign last_col = col == CW'(KEY_W - 1);
  assign last_px = last_col && row == RW'(KEY_H - 1);
  assign bad_key = key_q >= KW'(NUM_KEYS);
  assign x_full = base_x + XI'(col);
`ifdef KEY_RECT_BORDER_EN
  assign pix_colour = (col == '0 || last_col || row == '0 || row == RW'(KEY_H - 1)) ? '0 : colour_q;
`else
  assign pix_colour = colour_q;
`endif
  always_comb begin
    state_n = state;
    col_n = col;
    row_n = row;
    case (state)
      IDLE: state_n = pop ? LOAD : IDLE;
      LOAD: begin
        state_n = bad_key ? IDLE : DRAW;
        col_n = '0;
        row_n = '0;
      end
      DRAW: begin
        state_n = last_px ? DONE : DRAW;
        col_n = last_col ? '0 : col + 1'b1;
        row_n = last_col ? row + 1'b1 : row;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge iClock or negedge iResetn)
    if (!iResetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge iClock)
    if (push) mem[wp] <= {iReqKey, iReqColour};
  always_ff @(posedge iClock or negedge iResetn)
    if (!iResetn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      col <= '0;
      row <= '0;
      key_q <= '0;
      colour_q <= '0;
      base_x <= '0;
      oX <= '0;
      oY <= '0;
      oColour <= '0;
      oPlot <= 1'b0;
      oDone <= 1'b0;
      oDrop <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      col <= col_n;
      row <= row_n;
      if (pop) {key_q, colour_q} <= mem[rp];
      if (state == LOAD) base_x <= XI'(X_ORIGIN) + XI'(key_q) * XI'(KEY_W);
      oPlot <= state == DRAW;
      oDone <= state == DONE;
      oDrop <= state == LOAD && bad_key;
      if (state == DRAW) begin
        oX <= x_full[X_W-1:0];
        oY <= Y_W'(Y_ORIGIN) + Y_W'(row);
        oColour <= pix_colour;
      end
    end
endmodule

// File: doc/key_rect_painter.md
Name: key_rect_painter

Overview:
- Parametrised rectangle-fill drawing engine for the synth's on-screen piano.
- Accepts queued "paint key K in colour C" requests, e.g. for note-on highlight and note-off restore.
- Streams one pixel per cycle as oX/oY/oColour/oPlot into the vga_adapter plot port.
- Generalises the single-display driver to N keys, configurable geometry, colour depth and a request FIFO for polyphonic updates.

Parameters:
- NUM_KEYS, 12: number of keys in the drawn row; key index range is 0..NUM_KEYS-1.
- KEY_W, 20: key rectangle width in pixels.
- KEY_H, 40: key rectangle height in pixels.
- X_ORIGIN, 40: x of the left edge of key 0.
- Y_ORIGIN, 160: y of the top edge of all keys.
- X_W, 9: oX width; 320-wide screen.
- Y_W, 8: oY width; 240-high screen.
- COLOUR_W, 3: colour width.
- FIFO_DEPTH, 4: request queue entries; must be a power of 2, at least 2.
- Constraint: X_ORIGIN+NUM_KEYS*KEY_W must be 320 or less, and Y_ORIGIN+KEY_H must be 240 or less. These are checked by the bench, not by the RTL.

Ports:
- iClock  in  1  system clock (CLOCK_50).
- iResetn  in  1  asynchronous, active-low reset.
- iReqValid  in  1  request strobe.
- iReqKey  in  KW=$clog2(NUM_KEYS+1)  key index.
- iReqColour  in  COLOUR_W  fill colour.
- oReqReady  out  1  FIFO can accept a request.
- oX  out  X_W  pixel x.
- oY  out  Y_W  pixel y.
- oColour  out  COLOUR_W  pixel colour.
- oPlot  out  1  pixel write enable.
- oBusy  out  1  engine not in IDLE, or FIFO non-empty.
- oDone  out  1  one-cycle pulse when a rectangle completes.
- oDrop  out  1  one-cycle pulse when an out-of-range request is discarded.

Behaviour:
- Reset (asynchronous, iResetn=0):
  - FIFO emptied; state=IDLE; counters cleared.
  - oPlot=0, oX=0, oY=0, oColour=0, oDone=0, oDrop=0, oBusy=0.
  - oReqReady=1 once reset is released.
- Accept rule:
  - A request is pushed when iReqValid && oReqReady at a rising edge.
  - oReqReady = !full, computed from the registered count only. A pop in the same cycle does not make a full FIFO accept.
  - A valid request against a full FIFO is not accepted; the producer must hold it.
  - Push and pop in the same cycle on a non-full, non-empty FIFO are both performed; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM (all outputs registered):
  - IDLE: if FIFO non-empty, pop and go to LOAD.
  - LOAD: latch key and colour; col=0, row=0.
    - If key is NUM_KEYS or greater: pulse oDrop and go to IDLE; no pixels are plotted.
    - Otherwise go to DRAW.
  - DRAW: each cycle output:
    - oPlot=1
    - oX=X_ORIGIN+key*KEY_W+col
    - oY=Y_ORIGIN+row
    - oColour=latched colour
  - DRAW counter advance:
    - col increments each cycle.
    - When col==KEY_W-1: col=0, row increments.
    - When col==KEY_W-1 and row==KEY_H-1: go to DONE.
  - DONE: oDone=1 for one cycle, oPlot=0, then IDLE.
- Output timing:
  - oPlot is 0 in every state other than DRAW.
  - oX, oY and oColour hold their last values outside DRAW.
- Arithmetic: x computed at X_W+2 bits internally, then truncated to X_W. The parameter constraints guarantee no truncation loss.
- Latency: request accepted at edge t into an empty FIFO with the engine idle:
  - LOAD at t+2.
  - First pixel visible after edge t+3.
  - Exactly KEY_W*KEY_H consecutive plot cycles.
  - oDone in the following cycle.
- Ordering: back-to-back queued requests are drawn in FIFO order. Each costs 3 non-plot cycles: IDLE, LOAD, DONE.
- Reset mid-DRAW aborts immediately. No further oPlot; no oDone for the aborted rectangle; queued requests are lost.

Optional Feature:
- Macro: KEY_RECT_BORDER_EN.
- Defined: pixels with col==0, col==KEY_W-1, row==0 or row==KEY_H-1 are plotted with colour 0 (black outline). Interior pixels use the request colour. Pixel count and timing are unchanged.
- Undefined: every pixel uses the request colour.

Test Plan:
- Key 0, colour 3'b100, defaults → 800 plot cycles. First pixel (40,160), last pixel (59,199), all colour 4. One oDone; oBusy low afterwards.
- Key 11, colour 3'b010 → x spans 260..279 and y spans 160..199, with exactly 800 plots.
- Key 12 (out of range) → oDrop pulse, zero plots, no oDone. FIFO returns to empty.
- While drawing key 0, push keys 1,2,3,4,5 with iReqValid held:
  - oReqReady drops after 4 entries are queued.
  - The 5th request is accepted when the first pop occurs.
  - Six rectangles are drawn in order with six oDone pulses.
- Assert iResetn=0 at the 100th plot → oPlot=0 from that point, with no oDone. After release, oReqReady=1 and a new request draws normally.
- With KEY_RECT_BORDER_EN, key 3, colour 3'b111:
  - Pixel (100,160) has colour 0.
  - Pixel (101,161) has colour 7.
  - Pixel (119,199) has colour 0.
  - Total plots are 800.
